eeprom_wr: RTL and testbench

- I2C-style master controller that performs single-byte random writes and random reads against the serial EEPROM behavioural model.
- The EEPROM has 2048 bytes and an 11-bit address.
- Sits between the system-side test/control logic (parallel request interface) and the two-wire bus (scl, open-drain sda) that the EEPROM model responds on.
- Generates all bus timing, START / repeated-START / STOP, ACK checking, and the master NACK on reads.

---
 rtl/eeprom_wr.sv | 215 +++++++++++++++++++++
 tb/tb_eeprom_wr.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_wr.sv
// Two-wire master issuing single-byte random writes and random reads to an
// 11-bit-addressed serial EEPROM; all bus timing derived from CLK_DIV quarters.
module eeprom_wr #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic        rd,
    input  logic [10:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic        nack_err,
    output logic        scl,
    inout  wire         sda
);
    localparam int unsigned QW = 8;
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;

    typedef enum logic [3:0] {
        IDLE, START, SEND_BIT, ACK_CHK, RSTART, RECV_BIT, MNACK, STOP, DONE
    } state_t;

    state_t        state, state_d;
    logic [QW-1:0] q_cnt, q_cnt_d;
    logic [1:0]    qtr, qtr_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [1:0]    byte_idx, byte_d;
    logic          is_rd, is_rd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] shift, shift_d;
    logic          ack_bad, ack_bad_d;
    logic [DW-1:0] rdata_d;
    logic          busy_d, done_d, nack_err_d, scl_d;
    logic          sda_oe, sda_oe_d;
    logic          tick, slot_end, smp;
    logic [DW-1:0] tx_byte;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // START occupies three quarters, every other bus slot four
    assign tick     = (q_cnt == QW'(CLK_DIV - 1));
    assign slot_end = tick && (qtr == ((state == START) ? 2'd2 : 2'd3));
    assign smp      = tick && (qtr == 2'd2);

    always_comb begin
        tx_byte = '0;
        case (byte_idx)
            2'd0:    tx_byte = {4'b1010, addr_q[10:8], 1'b0};
            2'd1:    tx_byte = addr_q[7:0];
            2'd2:    tx_byte = wdata_q;
            default: tx_byte = {4'b1010, addr_q[10:8], 1'b1};
        endcase
    end

    always_comb begin
        state_d    = state;
        q_cnt_d    = q_cnt;
        qtr_d      = qtr;
        bit_d      = bit_cnt;
        byte_d     = byte_idx;
        is_rd_d    = is_rd;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        shift_d    = shift;
        ack_bad_d  = ack_bad;
        rdata_d    = rdata;
        nack_err_d = nack_err;
        scl_d      = 1'b1;
        sda_oe_d   = sda_oe;

        if (state == IDLE || state == DONE) begin
            q_cnt_d = '0;
            qtr_d   = '0;
        end else if (tick) begin
            q_cnt_d = '0;
            qtr_d   = slot_end ? 2'd0 : qtr + 2'd1;
        end else begin
            q_cnt_d = q_cnt + QW'(1);
        end

        // scl low in quarters 0-1, high in 2-3; sda moves only in quarter 1
        case (state)
            IDLE: begin
                sda_oe_d = 1'b0;
                if (wr || rd) begin
                    addr_d     = addr;
                    wdata_d    = wdata;
                    is_rd_d    = ~wr;
                    byte_d     = 2'd0;
                    bit_d      = 3'd0;
                    ack_bad_d  = 1'b0;
                    nack_err_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                scl_d    = (qtr != 2'd2);
                sda_oe_d = (qtr != 2'd0);
                if (slot_end) state_d = SEND_BIT;
            end
            SEND_BIT: begin
                scl_d = qtr[1];
                if (qtr == 2'd1) sda_oe_d = ~tx_byte[~bit_cnt];
                if (slot_end) begin
                    bit_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_d = ACK_CHK;
                end
            end
            ACK_CHK: begin
                scl_d = qtr[1];
                if (qtr == 2'd1) sda_oe_d = 1'b0;
                if (smp) ack_bad_d = sda;
                if (slot_end) begin
                    if (ack_bad) begin
                        state_d = STOP;
                    end else begin
                        case (byte_idx)
                            2'd0: begin
                                byte_d  = 2'd1;
                                state_d = SEND_BIT;
                            end
                            2'd1: begin
                                byte_d  = is_rd ? 2'd3 : 2'd2;
                                state_d = is_rd ? RSTART : SEND_BIT;
                            end
                            2'd2:    state_d = STOP;
                            default: state_d = RECV_BIT;
                        endcase
                    end
                end
            end
            RSTART: begin
                scl_d = qtr[1];
                if (qtr == 2'd1 || qtr == 2'd2) sda_oe_d = 1'b0;
                if (qtr == 2'd3) sda_oe_d = 1'b1;
                if (slot_end) state_d = SEND_BIT;
            end
            RECV_BIT: begin
                scl_d = qtr[1];
                if (qtr == 2'd1) sda_oe_d = 1'b0;
                if (smp) shift_d = {shift[DW-2:0], sda};
                if (slot_end) begin
                    bit_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_d = MNACK;
                end
            end
            MNACK: begin
                scl_d = qtr[1];
                if (qtr == 2'd1) sda_oe_d = 1'b0;
                if (slot_end) state_d = STOP;
            end
            STOP: begin
                scl_d = qtr[1];
                if (qtr == 2'd1 || qtr == 2'd2) sda_oe_d = 1'b1;
                if (qtr == 2'd3) sda_oe_d = 1'b0;
                if (slot_end) begin
                    nack_err_d = ack_bad;
                    if (is_rd && !ack_bad) rdata_d = shift;
                    state_d = DONE;
                end
            end
            DONE: begin
                sda_oe_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            q_cnt    <= '0;
            qtr      <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            is_rd    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shift    <= '0;
            ack_bad  <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack_err <= 1'b0;
            scl      <= 1'b1;
            sda_oe   <= 1'b0;
        end else begin
            state    <= state_d;
            q_cnt    <= q_cnt_d;
            qtr      <= qtr_d;
            bit_cnt  <= bit_d;
            byte_idx <= byte_d;
            is_rd    <= is_rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            shift    <= shift_d;
            ack_bad  <= ack_bad_d;
            rdata    <= rdata_d;
            busy     <= busy_d;
            done     <= done_d;
            nack_err <= nack_err_d;
            scl      <= scl_d;
            sda_oe   <= sda_oe_d;
        end
    end
endmodule

// File: tb/tb_eeprom_wr.sv
// Bench for eeprom_wr: EEPROM bus model, byte/completion scoreboards, directed transactions.
module tb_eeprom_wr;
    localparam int unsigned CD = 6;

    logic        clk, rst_n, wr, rd;
    logic [10:0] addr;
    logic [7:0]  wdata, rdata;
    logic        busy, done, nack_err, scl;
    wire         sda;
    logic        slv_drv;

    pullup (sda);
    assign sda = slv_drv ? 1'b0 : 1'bz;

    eeprom_wr #(.CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .nack_err(nack_err),
        .scl(scl), .sda(sda)
    );

    typedef struct packed { logic [7:0] rdata; logic nack; } exp_t;

    int          n_tests = 0, n_fail = 0;
    int          done_cnt = 0, bytes_seen = 0, scl_pulses = 0;
    logic        seen_rise = 1'b0;
    exp_t        sb_q[$];
    logic [7:0]  bq[$];

    logic [7:0]  mem [0:2047];
    logic        s_present, s_active, s_tx, s_to_tx;
    int          s_bitc, s_byte;
    logic [7:0]  s_sh, s_txb;
    logic [10:0] s_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic log_byte(input logic [7:0] b);
        bytes_seen++;
        if (bq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_byte: got %02h expected none", b);
        end else begin
            check("bus_byte", 32'(b), 32'(bq.pop_front()));
        end
    endtask

    task automatic slave_rx();
        case (s_byte)
            0: if (s_sh[7:4] == 4'hA) begin
                slv_drv = s_present;
                if (s_sh[0]) s_to_tx = 1'b1;
                else s_ptr[10:8] = s_sh[3:1];
            end
            1: begin
                s_ptr[7:0] = s_sh;
                slv_drv = s_present;
            end
            default: begin
                if (s_present) mem[s_ptr] = s_sh;
                s_ptr = s_ptr + 11'd1;
                slv_drv = s_present;
            end
        endcase
        s_byte++;
    endtask

    // EEPROM model: watches the bus on clk, ACKs and serves reads
    initial begin : slave
        logic c, s, p_scl, p_sda;
        p_scl = 1'b1; p_sda = 1'b1;
        slv_drv = 1'b0; s_active = 1'b0; s_tx = 1'b0; s_to_tx = 1'b0;
        s_bitc = 0; s_byte = 0; s_sh = '0; s_txb = '0; s_ptr = '0;
        forever begin
            @(posedge clk);
            c = scl;
            s = (sda !== 1'b0);
            if (busy) begin
                if (!p_scl && c) seen_rise = 1'b1;
                if (p_scl && !c && seen_rise) scl_pulses++;
            end
            if (p_scl && c && p_sda && !s) begin
                s_active = 1'b1; s_tx = 1'b0; s_to_tx = 1'b0;
                s_bitc = 0; s_byte = 0; slv_drv = 1'b0;
            end else if (p_scl && c && !p_sda && s) begin
                s_active = 1'b0; slv_drv = 1'b0;
            end else if (s_active) begin
                if (!p_scl && c) begin
                    if (s_bitc < 8 && !s_tx) s_sh = {s_sh[6:0], s};
                    s_bitc++;
                end else if (p_scl && !c) begin
                    if (s_bitc == 8) begin
                        if (s_tx) begin
                            log_byte(s_txb);
                            slv_drv = 1'b0;
                        end else begin
                            log_byte(s_sh);
                            slave_rx();
                        end
                    end else if (s_bitc == 9) begin
                        s_bitc = 0;
                        slv_drv = 1'b0;
                        if (s_to_tx) begin
                            s_tx = 1'b1; s_to_tx = 1'b0;
                            s_txb = mem[s_ptr];
                            slv_drv = s_present && !s_txb[7];
                        end else if (s_tx) begin
                            s_active = 1'b0;
                        end
                    end else if (s_tx && s_bitc > 0 && s_bitc < 8) begin
                        slv_drv = s_present && !s_txb[3'(7 - s_bitc)];
                    end
                end
            end
            p_scl = c;
            p_sda = s;
        end
    end

    // Completion monitor: pops the expected result on every done pulse
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                done_cnt++;
                check("busy_low_at_done", 32'(busy), 32'd0);
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_unexpected: got done expected none");
                end else begin
                    e = sb_q.pop_front();
                    check("rdata", 32'(rdata), 32'(e.rdata));
                    check("nack_err", 32'(nack_err), 32'(e.nack));
                end
            end
        end
    end

    task automatic push_bytes(input int n, input logic [7:0] b0, b1, b2, b3);
        if (n > 0) bq.push_back(b0);
        if (n > 1) bq.push_back(b1);
        if (n > 2) bq.push_back(b2);
        if (n > 3) bq.push_back(b3);
    endtask

    task automatic start_txn(input logic w, r, input logic [10:0] a, input logic [7:0] d,
                             input logic push_sb, input logic [7:0] exp_rd, input logic exp_nack);
        exp_t e;
        if (push_sb) begin
            e.rdata = exp_rd;
            e.nack  = exp_nack;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        wr = w; rd = r; addr = a; wdata = d;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
        check("busy_after_capture", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int max_cyc);
        logic seen, dip;
        int   n;
        seen = 1'b0; dip = 1'b0; n = 0;
        while (!seen && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            else if (!busy) dip = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_held", 32'(dip), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_read();
        int base, guard;
        push_bytes(1, 8'hAA, 8'h00, 8'h00, 8'h00);
        start_txn(1'b0, 1'b1, 11'h5A3, 8'h00, 1'b0, 8'h00, 1'b0);
        base = bytes_seen; guard = 0;
        while (bytes_seen == base && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        check("ctrl_before_reset", 32'(bytes_seen - base), 32'd1);
        repeat (4 * 4 * CD) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda === 1'b1), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
        s_present = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk); #1;
        check("reset_scl", 32'(scl), 32'd1);
        check("reset_sda", 32'(sda === 1'b1), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_nack", 32'(nack_err), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        push_bytes(3, 8'hAA, 8'hA3, 8'h3C, 8'h00);
        start_txn(1'b1, 1'b0, 11'h5A3, 8'h3C, 1'b1, 8'h00, 1'b0);
        wait_done(20000);
        check("mem_5a3", 32'(mem[11'h5A3]), 32'h3C);

        push_bytes(4, 8'hAA, 8'hA3, 8'hAB, 8'h3C);
        start_txn(1'b0, 1'b1, 11'h5A3, 8'h00, 1'b1, 8'h3C, 1'b0);
        wait_done(20000);

        push_bytes(3, 8'hA0, 8'h00, 8'h01, 8'h00);
        start_txn(1'b1, 1'b0, 11'h000, 8'h01, 1'b1, 8'h3C, 1'b0);
        wait_done(20000);
        push_bytes(3, 8'hAE, 8'hFF, 8'hFE, 8'h00);
        start_txn(1'b1, 1'b0, 11'h7FF, 8'hFE, 1'b1, 8'h3C, 1'b0);
        wait_done(20000);
        push_bytes(4, 8'hA0, 8'h00, 8'hA1, 8'h01);
        start_txn(1'b0, 1'b1, 11'h000, 8'h00, 1'b1, 8'h01, 1'b0);
        wait_done(20000);
        push_bytes(4, 8'hAE, 8'hFF, 8'hAF, 8'hFE);
        start_txn(1'b0, 1'b1, 11'h7FF, 8'h00, 1'b1, 8'hFE, 1'b0);
        wait_done(20000);

        // absent slave: stop after the control byte, rdata untouched
        s_present = 1'b0;
        seen_rise = 1'b0; scl_pulses = 0;
        push_bytes(1, 8'hA2, 8'h00, 8'h00, 8'h00);
        start_txn(1'b1, 1'b0, 11'h123, 8'h77, 1'b1, 8'hFE, 1'b1);
        wait_done(20000);
        check("noslave_scl_pulses", 32'(scl_pulses), 32'd9);
        s_present = 1'b1;

        // wr+rd together, then a write request while busy
        begin
            int base;
            base = done_cnt;
            push_bytes(3, 8'hA0, 8'hAA, 8'h5E, 8'h00);
            start_txn(1'b1, 1'b1, 11'h0AA, 8'h5E, 1'b1, 8'hFE, 1'b0);
            repeat (40) @(posedge clk); #1;
            wr = 1'b1; addr = 11'h300; wdata = 8'h11;
            @(posedge clk); #1 wr = 1'b0;
            wait_done(20000);
            repeat (200) @(posedge clk); #1;
            check("single_done", 32'(done_cnt - base), 32'd1);
            check("idle_after_ignored", 32'(busy), 32'd0);
            check("mem_0aa", 32'(mem[11'h0AA]), 32'h5E);
            check("mem_300_untouched", 32'(mem[11'h300]), 32'h00);
        end

        reset_mid_read();
        push_bytes(3, 8'hA0, 8'h10, 8'h55, 8'h00);
        start_txn(1'b1, 1'b0, 11'h010, 8'h55, 1'b1, 8'h00, 1'b0);
        wait_done(20000);
        push_bytes(4, 8'hA0, 8'h10, 8'hA1, 8'h55);
        start_txn(1'b0, 1'b1, 11'h010, 8'h00, 1'b1, 8'h55, 1'b0);
        wait_done(20000);

        repeat (20) @(posedge clk);
        check("sb_left", 32'(sb_q.size()), 32'd0);
        check("bytes_left", 32'(bq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
